// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared state encodings, request record and default timeout for the I2C register sequencer.
// No logic of its own; imported by the sequencer and its bench.
package i2c_reg_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        BYTE      = 3'd3,
        RDATA     = 3'd4,
        WAIT_IDLE = 3'd5,
        ABORT     = 3'd6
    } seq_state_t;

    localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'd60000;

    typedef struct packed {
        logic       rd;
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } txn_t;

    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rnw);
        return {dev, rnw};
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// Byte-level handshake between the register sequencer and the I2C master core.
// master = sequencer side (drives strobes and tx byte); slave = master-core side.
interface i2c_reg_sequencer_if;
    logic       m_start;
    logic       m_send;
    logic       m_receive;
    logic [7:0] m_datasend;
    logic       m_ready;
    logic       m_sended;
    logic       m_received;
    logic [7:0] m_datareceive;

    modport master (
        output m_start, m_send, m_receive, m_datasend,
        input  m_ready, m_sended, m_received, m_datareceive
    );

    modport slave (
        input  m_start, m_send, m_receive, m_datasend,
        output m_ready, m_sended, m_received, m_datareceive
    );
endinterface

// File: rtl/i2c_reg_sequencer_timer.sv
// Per-transaction watchdog: clears on request accept, counts while enabled, flags LIMIT reached.
// expired is combinational so the registered abort lands exactly LIMIT cycles after START.
module i2c_seq_timer #(
    parameter logic [15:0] LIMIT = 16'd60000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    // true in the cycle whose closing edge takes count to LIMIT
    assign expired = enable && !clear && (({1'b0, count} + 17'd1) == {1'b0, LIMIT});

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Sequences one I2C register read/write over a byte-level master core; done/err pulse ends each request.
// Latency is bus-bound and capped by TIMEOUT_CYC; req is taken only in IDLE with m_ready=1, otherwise ignored.
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  rd,
    input  logic [6:0]            dev_addr,
    input  logic [7:0]            reg_addr,
    input  logic [7:0]            wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            rdata,
    i2c_reg_sequencer_if.master   m
);
    seq_state_t state, state_nxt;
    txn_t       txn;
    logic [1:0] bcnt, bcnt_nxt;
    logic [7:0] dsend, dsend_nxt;
    logic       start_q, start_nxt;
    logic       send_q, send_nxt;
    logic       recv_q, recv_nxt;
    logic       done_nxt, err_nxt;
    logic [7:0] rdata_nxt;
    logic       accept;
    logic       sended_q, received_q;
    logic       sended_rise, sended_fall, received_rise;
    logic       expired;

    assign sended_rise   =  m.m_sended   & ~sended_q;
    assign sended_fall   = ~m.m_sended   &  sended_q;
    assign received_rise =  m.m_received & ~received_q;

    // timer is zeroed on the accept edge, so it reads 0 throughout START
    i2c_seq_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (state != IDLE),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        dsend_nxt = dsend;
        start_nxt = 1'b0;
        send_nxt  = send_q;
        recv_nxt  = recv_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = rdata;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                if (req && m.m_ready) begin
                    accept    = 1'b1;
                    state_nxt = START;
                    dsend_nxt = addr_byte(dev_addr, 1'b0);
                    start_nxt = 1'b1;
                    bcnt_nxt  = 2'd0;
                    send_nxt  = 1'b0;
                    recv_nxt  = 1'b0;
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!m.m_ready) state_nxt = BYTE;
            BYTE: begin
                if (m.m_ready) begin
                    // master stopped early: a byte was NACKed
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    send_nxt  = 1'b0;
                    recv_nxt  = 1'b0;
                end else if (sended_fall) begin
                    send_nxt = 1'b0;
                    if (recv_q) begin
                        recv_nxt  = 1'b0;
                        state_nxt = RDATA;
                    end
                end else if (sended_rise) begin
                    case (bcnt)
                        2'd0: begin
                            dsend_nxt = txn.reg_addr;
                            send_nxt  = 1'b1;
                            bcnt_nxt  = 2'd1;
                        end
                        2'd1: begin
                            bcnt_nxt = 2'd2;
                            if (txn.rd) begin
                                dsend_nxt = addr_byte(txn.dev_addr, 1'b1);
                                start_nxt = 1'b1;
                                send_nxt  = 1'b0;
                            end else begin
                                dsend_nxt = txn.wdata;
                                send_nxt  = 1'b1;
                            end
                        end
                        2'd2: begin
                            if (txn.rd) begin
                                recv_nxt = 1'b1;
                                send_nxt = 1'b0;
                                bcnt_nxt = 2'd3;
                            end else begin
                                state_nxt = WAIT_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RDATA: begin
                if (m.m_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (received_rise) begin
                    rdata_nxt = m.m_datareceive;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (m.m_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ABORT:   if (m.m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // timeout overrides anything decided above, including edges seen this cycle
        if (expired && state != ABORT) begin
            state_nxt = ABORT;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            start_nxt = 1'b0;
            send_nxt  = 1'b0;
            recv_nxt  = 1'b0;
            bcnt_nxt  = bcnt;
            dsend_nxt = dsend;
            rdata_nxt = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            txn        <= '0;
            bcnt       <= '0;
            dsend      <= '0;
            start_q    <= 1'b0;
            send_q     <= 1'b0;
            recv_q     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            sended_q   <= 1'b0;
            received_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            bcnt       <= bcnt_nxt;
            dsend      <= dsend_nxt;
            start_q    <= start_nxt;
            send_q     <= send_nxt;
            recv_q     <= recv_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            rdata      <= rdata_nxt;
            sended_q   <= m.m_sended;
            received_q <= m.m_received;
            if (accept) txn <= {rd, dev_addr, reg_addr, wdata};
        end
    end

    assign busy         = (state != IDLE);
    assign m.m_start    = start_q;
    assign m.m_send     = send_q;
    assign m.m_receive  = recv_q;
    assign m.m_datasend = dsend;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural byte-level master plus a done-driven scoreboard.
// Bus events are logged as {kind,byte}: 1=start 2=byte 3=restart 4=read+NACK 5=stop.
module tb_i2c_reg_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       rd = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, err;
    logic [7:0] rdata;

    i2c_reg_sequencer_if bus();

    i2c_reg_sequencer #(.TIMEOUT_CYC(16'd200)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .rd       (rd),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .m        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [7:0]  rdata;
        logic [71:0] bus;
    } exp_t;

    exp_t        sb_q[$];
    string       name_q[$];
    int          n_tests = 0, n_fail = 0;
    int          done_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
    int          excl_viol = 0, ev_cnt = 0;
    logic [71:0] bus_log = '0;
    bit          nack_addr = 1'b0, stuck = 1'b0;
    logic [7:0]  rx_byte = 8'h3C;

    localparam int M_IDLE = 0, M_XFER = 1, M_ACKED = 2, M_RECV = 3, M_RXH = 4, M_STOP = 5, M_STUCK = 6;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [11:0] ev);
        bus_log = {bus_log[59:0], ev};
        ev_cnt++;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // master core model, evaluated at negedge so DUT outputs are settled
    initial begin : master_model
        int         st;
        int         cnt;
        int         pend;
        logic [7:0] pbyte;
        st = M_IDLE; cnt = 0; pend = 0; pbyte = '0;
        bus.m_ready = 1'b1; bus.m_sended = 1'b0; bus.m_received = 1'b0; bus.m_datareceive = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                st = M_IDLE;
                bus.m_ready = 1'b1; bus.m_sended = 1'b0; bus.m_received = 1'b0; bus.m_datareceive = '0;
                bus_log = '0;
            end else begin
                case (st)
                    M_IDLE: if (bus.m_start) begin
                        push_ev({4'h1, bus.m_datasend});
                        bus.m_ready = 1'b0;
                        cnt = 4;
                        st = stuck ? M_STUCK : (nack_addr ? M_STOP : M_XFER);
                    end
                    M_XFER: if (cnt == 0) begin
                        bus.m_sended = 1'b1; cnt = 6; pend = 0; st = M_ACKED;
                    end else cnt--;
                    M_ACKED: begin
                        if (bus.m_send)    begin pend = 2; pbyte = bus.m_datasend; end
                        if (bus.m_start)   begin pend = 3; pbyte = bus.m_datasend; end
                        if (bus.m_receive) pend = 4;
                        if (cnt == 0) begin
                            bus.m_sended = 1'b0;
                            if (pend == 2 || pend == 3) begin
                                push_ev({pend[3:0], pbyte}); cnt = 4; st = M_XFER;
                            end else if (pend == 4) begin
                                cnt = 3; st = M_RECV;
                            end else begin
                                cnt = 2; st = M_STOP;
                            end
                        end else cnt--;
                    end
                    M_RECV: if (cnt == 0) begin
                        bus.m_datareceive = rx_byte; bus.m_received = 1'b1;
                        push_ev({4'h4, rx_byte}); cnt = 3; st = M_RXH;
                    end else cnt--;
                    M_RXH: if (cnt == 0) begin
                        bus.m_received = 1'b0; cnt = 2; st = M_STOP;
                    end else cnt--;
                    M_STOP: if (cnt == 0) begin
                        push_ev(12'h500); bus.m_ready = 1'b1; st = M_IDLE;
                    end else cnt--;
                    M_STUCK: if (!stuck) begin
                        bus.m_ready = 1'b1; st = M_IDLE;
                    end
                    default: st = M_IDLE;
                endcase
            end
        end
    end

    // scoreboard monitor: every done pops one expectation
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (int'(bus.m_start) + int'(bus.m_send) + int'(bus.m_receive) > 1) excl_viol++;
                if (bus.m_start) start_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 err=%0b, required no done", err);
                    end else begin
                        e  = sb_q.pop_front();
                        nm = name_q.pop_front();
                        check({nm, "_err"},   72'(err),   72'(e.err));
                        check({nm, "_rdata"}, 72'(rdata), 72'(e.rdata));
                        check({nm, "_bus"},   bus_log,    e.bus);
                    end
                    bus_log = '0;
                end
            end
        end
    end

    task automatic issue(input bit r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd,
                         input bit track, input string nm, input logic e_err,
                         input logic [7:0] e_rdata, input logic [71:0] e_bus);
        int   guard;
        exp_t e;
        guard = 0;
        while ((busy || !bus.m_ready) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check({nm, "_idle_wait"}, 72'(busy), 72'(0));
        @(negedge clk);
        rd = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
        if (track) begin
            e.err = e_err; e.rdata = e_rdata; e.bus = e_bus;
            sb_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int base;
        int g;
        base = done_cnt;
        g = 0;
        while (done_cnt == base && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (done_cnt == base) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, required one", nm, g);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int dc;
        int base_ev;
        int g;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 72'({busy, done, err, bus.m_start, bus.m_send, bus.m_receive}), 72'(0));
        check("rst_datasend", 72'(bus.m_datasend), 72'(0));
        check("rst_rdata", 72'(rdata), 72'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1, "wr", 1'b0, 8'h00,
              {24'h0, 12'h1A0, 12'h210, 12'h2A5, 12'h500});
        wait_done("wr");

        rx_byte = 8'h3C;
        issue(1'b1, 7'h50, 8'h22, 8'h00, 1'b1, "rd", 1'b0, 8'h3C,
              {12'h0, 12'h1A0, 12'h222, 12'h3A1, 12'h43C, 12'h500});
        wait_done("rd");

        nack_addr = 1'b1;
        rx_byte = 8'h77;
        issue(1'b1, 7'h50, 8'h22, 8'h00, 1'b1, "nack", 1'b1, 8'h3C, {48'h0, 12'h1A0, 12'h500});
        wait_done("nack");
        nack_addr = 1'b0;

        stuck = 1'b1;
        issue(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1, "tmo", 1'b1, 8'h3C, {60'h0, 12'h1A0});
        wait_done("tmo");
        check("tmo_latency", 72'(done_cyc - start_cyc), 72'(200));
        repeat (10) @(negedge clk);
        check("tmo_busy_hold", 72'(busy), 72'(1));
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        check("tmo_busy_release", 72'(busy), 72'(0));

        // reset while the register-address byte of a write is on the bus
        base_ev = ev_cnt;
        issue(1'b0, 7'h21, 8'h05, 8'h99, 1'b0, "rstw", 1'b0, 8'h00, 72'h0);
        g = 0;
        while (ev_cnt < base_ev + 2 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("rstw_reached_byte2", 72'(ev_cnt - base_ev), 72'(2));
        repeat (2) @(negedge clk);
        dc = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        check("rstw_ctrl", 72'({busy, done, err, bus.m_start, bus.m_send, bus.m_receive}), 72'(0));
        check("rstw_data", 72'({bus.m_datasend, rdata}), 72'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rstw_no_done", 72'(done_cnt - dc), 72'(0));

        issue(1'b0, 7'h21, 8'h05, 8'h99, 1'b1, "wr2", 1'b0, 8'h00,
              {24'h0, 12'h142, 12'h205, 12'h299, 12'h500});
        wait_done("wr2");

        // req pulses during a transaction must be ignored
        dc = done_cnt;
        issue(1'b0, 7'h50, 8'h01, 8'h5A, 1'b1, "bsy", 1'b0, 8'h00,
              {24'h0, 12'h1A0, 12'h201, 12'h25A, 12'h500});
        repeat (8) @(negedge clk);
        rd = 1'b1; dev_addr = 7'h11; reg_addr = 8'hEE; wdata = 8'h00; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done("bsy");
        repeat (100) @(negedge clk);
        check("bsy_one_done", 72'(done_cnt - dc), 72'(1));
        check("bsy_no_restart", 72'(busy), 72'(0));

        check("sb_empty", 72'(sb_q.size()), 72'(0));
        check("strobe_exclusive", 72'(excl_viol), 72'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of stimulus by 50000 cycles, required completion");
        $fatal(1, "watchdog");
    end

endmodule
